// File: rtl/gpiotest_pkg.sv
// Shared definitions for the gpiotest serial blocks.
// Holds clock default, data width and the UART receive state type.
package gpiotest_pkg;

  localparam int DEFAULT_CLOCK_HZ = 12_000_000;
  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for asynchronous GPIO inputs, resets to 1.
// Ports: clk, reset (sync, active high), d (async in), q (synced out).
module gpio_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_uart_rx.sv
// 8N1 UART receiver (LSB first) for a GPIO pin; optional even parity
// with macro GPIO_UART_RX_PARITY_EN.
// Ports: clk, reset (sync, active high), rx (async line, idle high),
// rx_data/rx_valid/rx_ready (byte handshake), frame_err, overrun,
// parity_err (one-cycle pulses), busy (receiver not idle).
module gpio_uart_rx
  import gpiotest_pkg::*;
#(
  parameter int CLOCK_HZ  = DEFAULT_CLOCK_HZ,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_IDX = 3'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("gpio_uart_rx: CLKS_PER_BIT must be at least 4");
  end

  uart_rx_state_t state;
  uart_rx_state_t state_next;

  logic                      rx_s;
  logic                      rx_prev;
  logic                      fall;
  logic [CW-1:0]             cnt;
  logic                      expire;
  logic [2:0]                bits_left;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      stop_hit;
  logic                      byte_good;
  logic                      stop_bad;
  logic                      par_fail;

  gpio_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign fall   = rx_prev & ~rx_s;
  assign expire = (cnt == '0);

  // State register plus the bit timing / shift datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rx_prev   <= 1'b1;
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
    end else begin
      state   <= state_next;
      rx_prev <= rx_s;
      unique case (state)
        ST_IDLE: begin
          if (fall) cnt <= HALF_LOAD;
        end
        ST_START: begin
          if (expire) begin
            cnt       <= BIT_LOAD;
            bits_left <= LAST_IDX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (expire) begin
            cnt       <= BIT_LOAD;
            shreg     <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            bits_left <= bits_left - 3'd1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_PARITY: begin
          if (expire) cnt <= BIT_LOAD;
          else        cnt <= cnt - CW'(1);
        end
        ST_STOP: begin
          if (!expire) cnt <= cnt - CW'(1);
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (fall) state_next = ST_START;
      end
      ST_START: begin
        // A high start sample means the edge was a glitch
        if (expire) state_next = rx_s ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (expire && bits_left == '0) begin
`ifdef GPIO_UART_RX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef GPIO_UART_RX_PARITY_EN
      ST_PARITY: begin
        if (expire) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (expire) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef GPIO_UART_RX_PARITY_EN
  logic par_bad;

  // Even parity: data ones plus parity bit must be even
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad <= 1'b0;
    end else if (state == ST_PARITY && expire) begin
      par_bad <= rx_s ^ (^shreg);
    end
  end
`endif

  always_comb begin
    stop_hit = (state == ST_STOP) && expire;
    stop_bad = stop_hit && !rx_s;
`ifdef GPIO_UART_RX_PARITY_EN
    par_fail  = stop_hit && rx_s && par_bad;
    byte_good = stop_hit && rx_s && !par_bad;
`else
    par_fail  = 1'b0;
    byte_good = stop_hit && rx_s;
`endif
    busy = (state != ST_IDLE);
  end

  // Output holding register; a byte landing on a handshake replaces it
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_good && rx_valid && !rx_ready;
      if (byte_good && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef GPIO_UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= par_fail;
  end
`else
  assign parity_err = 1'b0;
  logic unused_par;
  assign unused_par = par_fail;
`endif

endmodule

// File: tb/tb_gpio_uart_rx.sv
// Self-checking bench for gpio_uart_rx: directed table, corner
// sequences and random frames against a transaction-level model.
module tb_gpio_uart_rx;

  localparam int CPB = 12_000_000 / 115_200;
`ifdef GPIO_UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // rx_valid rise, counted from the cycle the pin falls
  localparam int LAT = 2 + CPB / 2 + (9 + PB) * CPB + 1;
  localparam int GAP = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  gpio_uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;
  int last_rise = -1;
  int start_cyc = 0;
  logic pv = 1'b0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (parity_err) n_perr++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (rx_valid && !pv) last_rise = cyc;
    pv = rx_valid;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Always entered and left at posedge+1
  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par);
    start_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d[i], CPB);
    if (PB == 1) drive(par, CPB);
    drive(stop, CPB);
    drive(1'b1, GAP);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    int         ef;
    int         eo;
    int         ea;
  } vec_t;

  vec_t tbl[8];

  int bf, bo, bp, bg;
  logic [7:0] eq[$];
  logic mv;
  logic [7:0] md;
  int ef, eo, ep;

  initial begin
    tbl[0] = '{8'hA3, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0, 0};
    tbl[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 0, 1};
    tbl[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 0, 0, 0};
    tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 0, 1, 0};
    tbl[4] = '{8'h99, 1'b0, 1'b0, 1'b1, 8'h11, 1, 0, 0};
    tbl[5] = '{8'hC4, 1'b1, 1'b1, 1'b0, 8'hC4, 0, 0, 2};
    tbl[6] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0, 1};
    tbl[7] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 0, 0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {rx_valid, rx_data, frame_err, overrun,
                       parity_err, busy}, 0);
    reset = 1'b0;
    drive(1'b1, 10);

    // 0x55 latency and data
    rx_ready = 1'b1;
    bf = n_ferr; bo = n_ovr; bg = got.size();
    send_frame(8'h55, 1'b1, ^8'h55);
    chk("lat_rise", last_rise - start_cyc, LAT);
    chk("lat_cnt", got.size() - bg, 1);
    if (got.size() > bg) chk("lat_data", got[$], 8'h55);
    chk("lat_errs", (n_ferr - bf) + (n_ovr - bo), 0);

    // 20-cycle glitch
    bf = n_ferr; bg = got.size();
    start_cyc = cyc;
    drive(1'b0, 20);
    chk("glitch_busy_hi", busy, 1);
    rx = 1'b1;
    repeat (36) @(posedge clk);
    #1;
    chk("glitch_busy_lo", busy, 0);
    drive(1'b1, 20);
    chk("glitch_none", (got.size() - bg) + (n_ferr - bf) + rx_valid, 0);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      bf = n_ferr; bo = n_ovr; bg = got.size();
      rx_ready = tbl[k].rdy;
      drive(1'b1, 2);
      send_frame(tbl[k].d, tbl[k].stop, ^tbl[k].d);
      chk($sformatf("tbl%0d_valid", k), rx_valid, tbl[k].ev);
      chk($sformatf("tbl%0d_ferr", k), n_ferr - bf, tbl[k].ef);
      chk($sformatf("tbl%0d_ovr", k), n_ovr - bo, tbl[k].eo);
      chk($sformatf("tbl%0d_acc", k), got.size() - bg, tbl[k].ea);
      if (tbl[k].ev)
        chk($sformatf("tbl%0d_data", k), rx_data, tbl[k].ed);
      else if (tbl[k].ea > 0 && got.size() > 0)
        chk($sformatf("tbl%0d_got", k), got[$], tbl[k].ed);
    end

    // Handshake coincident with completion
    rx_ready = 1'b0;
    drive(1'b1, 2);
    send_frame(8'h11, 1'b1, ^8'h11);
    chk("coin_hold", {rx_valid, rx_data}, {1'b1, 8'h11});
    bo = n_ovr; bg = got.size();
    fork
      send_frame(8'h22, 1'b1, ^8'h22);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 rx_ready = 1'b1;
      end
    join
    chk("coin_ovr", n_ovr - bo, 0);
    chk("coin_acc", got.size() - bg, 2);
    if (got.size() >= 2) begin
      chk("coin_first", got[got.size() - 2], 8'h11);
      chk("coin_second", got[$], 8'h22);
    end

    // Reset during bit 4 of 0xF0 with a byte pending
    rx_ready = 1'b0;
    drive(1'b1, 2);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    chk("pre_rst_valid", rx_valid, 1);
    bf = n_ferr; bo = n_ovr; bp = n_perr;
    drive(1'b0, 5 * CPB);
    rx = 1'b1;
    repeat (50) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_outs", {rx_valid, rx_data, frame_err, overrun,
                         parity_err, busy}, 0);
    reset = 1'b0;
    drive(1'b1, 6 * CPB);
    chk("rst_no_err", (n_ferr - bf) + (n_ovr - bo) + (n_perr - bp), 0);
    rx_ready = 1'b1;
    bg = got.size();
    send_frame(8'h0F, 1'b1, ^8'h0F);
    chk("rst_next_acc", got.size() - bg, 1);
    if (got.size() > 0) chk("rst_next_data", got[$], 8'h0F);

    // Break: line held low
    bf = n_ferr; bg = got.size();
    drive(1'b0, 3000);
    chk("brk_ferr", n_ferr - bf, 1);
    chk("brk_busy", busy, 0);
    drive(1'b1, 50);
    send_frame(8'h6E, 1'b1, ^8'h6E);
    chk("brk_after", got.size() - bg, 1);
    if (got.size() > 0) chk("brk_data", got[$], 8'h6E);

`ifdef GPIO_UART_RX_PARITY_EN
    bp = n_perr; bf = n_ferr; bg = got.size();
    send_frame(8'h07, 1'b1, 1'b0);
    chk("par_bad_perr", n_perr - bp, 1);
    chk("par_bad_ferr", n_ferr - bf, 0);
    chk("par_bad_acc", got.size() - bg + rx_valid, 0);
    bp = n_perr;
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_ok_perr", n_perr - bp, 0);
    chk("par_ok_acc", got.size() - bg, 1);
    if (got.size() > 0) chk("par_ok_data", got[$], 8'h07);
`else
    chk("par_tied", n_perr, 0);
`endif

    // Random frames against the transaction model
    rx_ready = 1'b1;
    drive(1'b1, 5);
    got.delete();
    eq.delete();
    mv = 1'b0; md = 8'h00;
    ef = 0; eo = 0; ep = 0;
    bf = n_ferr; bo = n_ovr; bp = n_perr;
    for (int k = 0; k < 12; k++) begin
      logic [7:0] d;
      logic stop, rdy, par, pok;
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom);
      par = ^d;
      if (PB == 1 && $urandom_range(0, 3) == 0) par = ~par;
      pok = (PB == 0) || (par == ^d);
      rx_ready = rdy;
      if (rdy && mv) begin
        eq.push_back(md);
        mv = 1'b0;
      end
      drive(1'b1, 2);
      send_frame(d, stop, par);
      if (!stop) ef++;
      else if (!pok) ep++;
      else if (mv) eo++;
      else if (rdy) eq.push_back(d);
      else begin
        mv = 1'b1;
        md = d;
      end
      chk($sformatf("rnd%0d_valid", k), rx_valid, mv);
      if (mv) chk($sformatf("rnd%0d_data", k), rx_data, md);
      chk($sformatf("rnd%0d_ferr", k), n_ferr - bf, ef);
      chk($sformatf("rnd%0d_ovr", k), n_ovr - bo, eo);
      chk($sformatf("rnd%0d_perr", k), n_perr - bp, ep);
      chk($sformatf("rnd%0d_acc", k), got.size(), eq.size());
    end
    for (int i = 0; i < eq.size() && i < got.size(); i++)
      chk($sformatf("rnd_byte%0d", i), got[i], eq[i]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
